// File: rtl/reg_file_wb_if.sv
// Register-file access bundle: two operand read ports, one debug read port,
// the write-back port and the committed-write counter.
interface reg_file_wb_if #(
  parameter int WIDTH = 32
);
  logic [4:0]       Ra;
  logic [4:0]       Rb;
  logic [WIDTH-1:0] Qa;
  logic [WIDTH-1:0] Qb;
  logic             We;
  logic [4:0]       Wr;
  logic [WIDTH-1:0] D;
  logic [4:0]       Rdbg;
  logic [WIDTH-1:0] Qdbg;
  logic [15:0]      Wcnt;

  modport master (
    output Ra, Rb, We, Wr, D, Rdbg,
    input  Qa, Qb, Qdbg, Wcnt
  );

  modport slave (
    input  Ra, Rb, We, Wr, D, Rdbg,
    output Qa, Qb, Qdbg, Wcnt
  );
endinterface

// File: rtl/reg_file_wb.sv
// 31 x WIDTH register file (r0 reads zero) with two combinational operand ports,
// a debug port and a saturating write counter; reads 0 cycles, writes commit on the edge.
module reg_file_wb #(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b0
) (
  input  logic         Clk,
  input  logic         Rst,
  reg_file_wb_if.slave bus
);

  logic [WIDTH-1:0] regs_q [1:31];
  logic [WIDTH-1:0] regs_d [1:31];
  logic [WIDTH-1:0] rf     [32];
  logic [31:0]      wen;
  logic [15:0]      wcnt_q;
  logic [15:0]      wcnt_d;

  // wen[0] is never set, so r0 writes vanish and never reach the counter.
  always_comb begin
    wen = '0;
    if (bus.We) begin
      wen[bus.Wr] = 1'b1;
    end
    wen[0] = 1'b0;
  end

  always_comb begin
    for (int i = 1; i < 32; i++) begin
      regs_d[i] = wen[i] ? bus.D : regs_q[i];
    end
    wcnt_d = wcnt_q;
    if ((|wen) && (wcnt_q != 16'hFFFF)) begin
      wcnt_d = wcnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      wcnt_q <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wcnt_q <= wcnt_d;
    end
  end

  always_comb begin
    rf[0] = '0;
    for (int i = 1; i < 32; i++) begin
      rf[i] = regs_q[i];
    end
  end

  // wen[addr] is exactly "We && Wr!=0 && Wr==addr", so it doubles as the bypass hit.
  assign bus.Qa   = (BYPASS && wen[bus.Ra]) ? bus.D : rf[bus.Ra];
  assign bus.Qb   = (BYPASS && wen[bus.Rb]) ? bus.D : rf[bus.Rb];
  assign bus.Qdbg = rf[bus.Rdbg];
  assign bus.Wcnt = wcnt_q;

endmodule
